fetch: RTL and testbench

Fetch stage of the SEQ Y86-64 processor. Holds the program counter and a byte-addressed instruction memory, and splits the instruction at the current PC into the fields the decode stage consumes: icode, ifun, rA, rB, valC, valP. It also runs the processor status state machine (run / halted / error), which freezes the PC once a halt, invalid instruction or bad fetch address is committed.

---
 rtl/fetch.sv | 137 +++++++++++++
 tb/tb_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Y86-64 SEQ fetch stage: PC register, byte-addressed instruction memory,
// instruction field split and the run/halted/error status state machine.
`timescale 1ns/1ps
module fetch #(
   parameter int unsigned MEM_BYTES = 1024,
   parameter logic [63:0] RESET_PC  = 64'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] pc_new,
   input  logic        imem_we,
   input  logic [63:0] imem_addr,
   input  logic [7:0]  imem_wdata,
   output logic [63:0] pc,
   output logic [3:0]  icode,
   output logic [3:0]  ifun,
   output logic [3:0]  rA,
   output logic [3:0]  rB,
   output logic [63:0] valC,
   output logic [63:0] valP,
   output logic [1:0]  stat,
   output logic [63:0] instr_count
);

   localparam int AW = $clog2(MEM_BYTES);

   localparam logic [1:0] ST_AOK = 2'd0;
   localparam logic [1:0] ST_HLT = 2'd1;
   localparam logic [1:0] ST_ADR = 2'd2;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      HALTED  = 2'd1,
      ERR_ADR = 2'd2,
      ERR_INS = 2'd3
   } state_e;

   state_e      state_q;
   logic [63:0] pc_q;
   logic [63:0] cnt_q;
   logic [7:0]  mem_q [MEM_BYTES];

   logic [7:0]  ib [10];
   logic        in_range;
   logic        has_reg;
   logic        adr_err;
   logic        ins_err;
   logic [3:0]  len;
   logic [1:0]  valc_off;
   logic [64:0] last_addr;
   logic [1:0]  istat;

   logic        unused_addr_hi;
   assign unused_addr_hi = ^imem_addr[63:AW];

   // Bytes beyond the end of memory wrap; such instructions are flagged ADR anyway.
   always_comb begin
      for (int k = 0; k < 10; k++) begin
         ib[k] = mem_q[pc_q[AW-1:0] + AW'(k)];
      end
   end

   always_comb begin
      in_range = (pc_q < 64'(MEM_BYTES));
      icode    = in_range ? ib[0][7:4] : 4'h0;
      ifun     = in_range ? ib[0][3:0] : 4'h0;

      len      = 4'd1;
      has_reg  = 1'b0;
      valc_off = 2'd0;
      case (icode)
         4'h2, 4'h6, 4'hA, 4'hB: begin len = 4'd2;  has_reg = 1'b1; end
         4'h3, 4'h4, 4'h5:       begin len = 4'd10; has_reg = 1'b1; valc_off = 2'd2; end
         4'h7, 4'h8:             begin len = 4'd9;  valc_off = 2'd1; end
         default:                len = 4'd1;
      endcase

      case (icode)
         4'h2, 4'h7: ins_err = (ifun > 4'd6);
         4'h6:       ins_err = (ifun > 4'd3);
         default:    ins_err = (icode > 4'hB) || (ifun != 4'h0);
      endcase

      // 65-bit sum so the end-of-instruction address never wraps past 2^64.
      last_addr = {1'b0, pc_q} + {61'd0, len} - 65'd1;
      adr_err   = (last_addr >= 65'(MEM_BYTES));

      if (adr_err)            istat = ST_ADR;
      else if (ins_err)       istat = 2'd3;
      else if (icode == 4'h0) istat = ST_HLT;
      else                    istat = ST_AOK;

      rA = has_reg ? ib[1][7:4] : 4'hF;
      rB = has_reg ? ib[1][3:0] : 4'hF;

      case (valc_off)
         2'd1:    valC = {ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2], ib[1]};
         2'd2:    valC = {ib[9], ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2]};
         default: valC = 64'd0;
      endcase

      valP = pc_q + 64'(len);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         cnt_q   <= 64'd0;
      end else if (state_q == RUN) begin
         case (istat)
            ST_AOK: begin
               pc_q  <= pc_new;
               cnt_q <= cnt_q + 64'd1;
            end
            ST_HLT: begin
               state_q <= HALTED;
               cnt_q   <= cnt_q + 64'd1;
            end
            ST_ADR:  state_q <= ERR_ADR;
            default: state_q <= ERR_INS;
         endcase
      end
   end

   // Program loading stays live through reset; contents survive it.
   always_ff @(posedge clk) begin
      if (imem_we) begin
         mem_q[imem_addr[AW-1:0]] <= imem_wdata;
      end
   end

   assign pc          = pc_q;
   assign instr_count = cnt_q;
   assign stat        = (state_q == RUN) ? istat : state_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for the fetch stage: directed programs, a table-driven reference model
// of the instruction format and status rules, and hand-computed spot values.
`timescale 1ns/1ps
module tb_fetch;

   localparam int unsigned MEM    = 1024;
   localparam logic [63:0] RST_PC = 64'd0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] pc_new;
   logic        imem_we;
   logic [63:0] imem_addr;
   logic [7:0]  imem_wdata;
   logic [63:0] pc;
   logic [3:0]  icode, ifun, rA, rB;
   logic [63:0] valC, valP;
   logic [1:0]  stat;
   logic [63:0] instr_count;

   fetch #(.MEM_BYTES(MEM), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n), .pc_new(pc_new),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .pc(pc), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
      .valC(valC), .valP(valP), .stat(stat), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: instruction properties as lookup tables indexed by icode.
   typedef struct {
      logic [3:0]  icode, ifun, ra, rb;
      logic [63:0] valc, valp;
      logic [1:0]  st;
   } dec_t;

   int unsigned LEN_T  [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
   bit          REG_T  [16] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};
   int unsigned COFF_T [16] = '{0, 0, 0, 2, 2, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
   int unsigned MAXF_T [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, 0, 0, 0, 0};

   logic [7:0]  mmem [MEM];
   logic [63:0] mpc  = RST_PC;
   logic [63:0] mcnt = 64'd0;
   int          mst  = 0;

   function automatic logic [7:0] mem_at(input logic [63:0] a);
      return mmem[int'(a % 64'(MEM))];
   endfunction

   function automatic dec_t model_decode(input logic [63:0] p);
      dec_t        d;
      logic [7:0]  b;
      int unsigned len, off;
      bit          adr, ins;
      d.icode = 4'h0;
      d.ifun  = 4'h0;
      if (p < 64'(MEM)) begin
         b = mem_at(p);
         d.icode = b[7:4];
         d.ifun  = b[3:0];
      end
      len    = LEN_T[d.icode];
      d.valp = p + 64'(len);
      d.ra   = 4'hF;
      d.rb   = 4'hF;
      if (REG_T[d.icode]) begin
         b = mem_at(p + 64'd1);
         d.ra = b[7:4];
         d.rb = b[3:0];
      end
      d.valc = 64'd0;
      off = COFF_T[d.icode];
      if (off != 0)
         for (int k = 0; k < 8; k++)
            d.valc = d.valc | (64'(mem_at(p + 64'(off) + 64'(k))) << (8 * k));
      adr = (p >= 64'(MEM)) || ((64'(MEM) - p) < 64'(len));
      ins = (d.icode > 4'hB) || (32'(d.ifun) > MAXF_T[d.icode]);
      if (adr)                d.st = 2'd2;
      else if (ins)           d.st = 2'd3;
      else if (d.icode == 0)  d.st = 2'd1;
      else                    d.st = 2'd0;
      return d;
   endfunction

   always @(negedge rst_n) begin
      mpc  = RST_PC;
      mcnt = 64'd0;
      mst  = 0;
   end

   dec_t md;
   always @(posedge clk) begin
      if (rst_n === 1'b1 && mst == 0) begin
         md = model_decode(mpc);
         case (md.st)
            2'd0:    begin mpc = pc_new; mcnt = mcnt + 64'd1; end
            2'd1:    begin mst = 1; mcnt = mcnt + 64'd1; end
            2'd2:    mst = 2;
            default: mst = 3;
         endcase
      end
      if (imem_we === 1'b1) mmem[int'(imem_addr % 64'(MEM))] = imem_wdata;
   end

   dec_t cd;
   always @(negedge clk) begin
      if (chk_en) begin
         cd = model_decode(mpc);
         check("pc",          pc,               mpc);
         check("icode",       64'(icode),       64'(cd.icode));
         check("ifun",        64'(ifun),        64'(cd.ifun));
         check("rA",          64'(rA),          64'(cd.ra));
         check("rB",          64'(rB),          64'(cd.rb));
         check("valC",        valC,             cd.valc);
         check("valP",        valP,             cd.valp);
         check("stat",        64'(stat),        (mst == 0) ? 64'(cd.st) : 64'(mst));
         check("instr_count", instr_count,      mcnt);
      end
   end

   task automatic wr(input logic [63:0] a, input logic [7:0] d);
      imem_addr  = a;
      imem_wdata = d;
      imem_we    = 1'b1;
      @(posedge clk); #1;
      imem_we    = 1'b0;
   endtask

   task automatic step(input int n);
      dec_t d;
      repeat (n) begin
         d = model_decode(mpc);
         pc_new = d.valp;
         @(posedge clk); #1;
      end
   endtask

   task automatic step_to(input logic [63:0] target);
      pc_new = target;
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst_n      = 1'b0;
      imem_we    = 1'b0;
      imem_addr  = 64'd0;
      imem_wdata = 8'h00;
      pc_new     = 64'd0;
      @(posedge clk); #1;
      for (int a = 0; a < int'(MEM); a++) wr(64'(a), 8'h00);

      // irmovq $0x0807060504030201, %rdx ; addq %rax, %rdx ; halt
      wr(64'd0, 8'h30); wr(64'd1, 8'hF2);
      for (int k = 0; k < 8; k++) wr(64'(2 + k), 8'(k + 1));
      wr(64'd10, 8'h60); wr(64'd11, 8'h02); wr(64'd12, 8'h00);
      chk_en = 1'b1;

      check("rst pc",    pc,               64'd0);
      check("rst count", instr_count,      64'd0);
      check("irm icode", 64'(icode),       64'h3);
      check("irm rA",    64'(rA),          64'hF);
      check("irm rB",    64'(rB),          64'h2);
      check("irm valC",  valC,             64'h0807060504030201);
      check("irm valP",  valP,             64'd10);
      check("irm stat",  64'(stat),        64'd0);

      rst_n = 1'b1;
      step(1);
      check("run1 pc",    pc,          64'd10);
      check("run1 count", instr_count, 64'd1);
      check("add rA",     64'(rA),     64'h0);
      check("add rB",     64'(rB),     64'h2);
      check("add valP",   valP,        64'd12);
      step(1);
      check("halt stat",  64'(stat),   64'd1);
      step(5);
      check("halted pc",    pc,          64'd12);
      check("halted count", instr_count, 64'd3);
      check("halted stat",  64'(stat),   64'd1);

      // Asynchronous reset in the middle of a cycle while halted.
      #2 rst_n = 1'b0;
      #1;
      check("async pc",    pc,          RST_PC);
      check("async count", instr_count, 64'd0);
      check("async stat",  64'(stat),   64'd0);
      wr(64'd10, 8'hC0);
      rst_n = 1'b1;
      step(1);
      check("ins icode", 64'(icode), 64'hC);
      check("ins stat",  64'(stat),  64'd3);
      step(3);
      check("ins pc",    pc,          64'd10);
      check("ins count", instr_count, 64'd1);
      check("ins hold",  64'(stat),   64'd3);

      // OPq ifun 3 is legal, ifun 4 is not.
      rst_n = 1'b0;
      wr(64'd0, 8'h63); wr(64'd1, 8'h12); wr(64'd2, 8'h64);
      rst_n = 1'b1;
      #1;
      check("op3 ifun", 64'(ifun), 64'h3);
      check("op3 stat", 64'(stat), 64'd0);
      check("op3 valP", valP,      64'd2);
      step(1);
      check("op4 stat", 64'(stat), 64'd3);
      step(2);
      check("op4 pc",   pc,        64'd2);

      // irmovq with a bad ifun straddling the end of memory: ADR wins.
      rst_n = 1'b0;
      wr(64'd0, 8'h10); wr(64'(MEM - 5), 8'h3F);
      rst_n = 1'b1;
      step_to(64'(MEM - 5));
      check("adr stat",  64'(stat), 64'd2);
      step(2);
      check("adr pc",    pc,          64'(MEM - 5));
      check("adr count", instr_count, 64'd1);

      // PC at the top of the 64-bit space must not wrap into range.
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      step_to(64'hFFFF_FFFF_FFFF_FFFF);
      check("top icode", 64'(icode), 64'h0);
      check("top stat",  64'(stat),  64'd2);
      step(1);
      check("top pc",    pc,          64'hFFFF_FFFF_FFFF_FFFF);
      check("top count", instr_count, 64'd1);

      @(negedge clk); #1;
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
